// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin arbitration of NREQ requesters onto the single
// register-file write port, plus a per-register busy scoreboard for hazard checks.
module regfile_wb_sched #(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic                     rf_wen,
    output logic [ADDR_W-1:0]        rf_addrW,
    output logic [DATA_W-1:0]        rf_din,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    input  logic [ADDR_W-1:0]        chk_addrA,
    input  logic [ADDR_W-1:0]        chk_addrB,
    output logic                     busyA,
    output logic                     busyB
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [PTR_W:0]   NREQ_L = (PTR_W+1)'(NREQ);
    localparam logic [PTR_W-1:0] LAST_L = PTR_W'(NREQ - 1);

    // A register address that names a real, writable register (not x0, in range)
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && (64'(a) < 64'(NREGS));
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a);
    endfunction

    logic                r_rf_wen;
    logic [ADDR_W-1:0]   r_rf_addr;
    logic [DATA_W-1:0]   r_rf_din;
    logic [NREGS-1:0]    r_busy;
    logic [PTR_W-1:0]    r_rr_ptr;

    logic                w_gnt_any;
    logic                w_gnt;
    logic [PTR_W-1:0]    w_gnt_idx;
    logic [PTR_W:0]      w_pos;
    logic [ADDR_W-1:0]   w_gnt_addr;
    logic [DATA_W-1:0]   w_gnt_data;
    logic [PTR_W-1:0]    w_rr_nxt;
    logic                w_claim;
    logic [NREGS-1:0]    w_busy_nxt;

    // Round-robin search starting at r_rr_ptr, wrapping modulo NREQ
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_pos     = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            w_pos = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_pos >= NREQ_L) begin
                w_pos = w_pos - NREQ_L;
            end
            if (!w_gnt_any && req_valid[w_pos[PTR_W-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_pos[PTR_W-1:0];
            end
        end
    end

    assign w_gnt      = w_gnt_any && rst_n && !flush;
    assign w_gnt_addr = req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
    assign w_gnt_data = req_data[w_gnt_idx*DATA_W +: DATA_W];
    assign w_rr_nxt   = (w_gnt_idx == LAST_L) ? '0 : w_gnt_idx + PTR_W'(1);

    always_comb begin
        req_ready = '0;
        if (w_gnt) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // A WAW claim may proceed on the very cycle the older write retires
    assign iss_ready = rst_n && !flush &&
                       (!addr_ok(iss_addr) || !r_busy[to_idx(iss_addr)] ||
                        (r_rf_wen && (r_rf_addr == iss_addr)));

    assign w_claim = iss_valid && iss_ready && addr_ok(iss_addr);

    assign busyA = addr_ok(chk_addrA) && r_busy[to_idx(chk_addrA)];
    assign busyB = addr_ok(chk_addrB) && r_busy[to_idx(chk_addrB)];

    // Retirement clears first so a same-edge claim of the same register wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_rf_wen) begin
            w_busy_nxt[to_idx(r_rf_addr)] = 1'b0;
        end
        if (w_claim) begin
            w_busy_nxt[to_idx(iss_addr)] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rf_wen  <= 1'b0;
            r_rf_addr <= '0;
            r_rf_din  <= '0;
            r_busy    <= '0;
            r_rr_ptr  <= '0;
        end else begin
            if (w_gnt) begin
                r_rf_wen  <= addr_ok(w_gnt_addr);
                r_rf_addr <= w_gnt_addr;
                r_rf_din  <= w_gnt_data;
                r_rr_ptr  <= w_rr_nxt;
            end else begin
                r_rf_wen  <= 1'b0;
            end
            r_busy <= flush ? '0 : w_busy_nxt;
        end
    end

    assign rf_wen   = r_rf_wen;
    assign rf_addrW = r_rf_addr;
    assign rf_din   = r_rf_din;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: per-cycle vector table with hand-derived expectations,
// registered write-port results checked through a scoreboard queue.
module tb_regfile_wb_sched;

    localparam int unsigned NREQ   = 3;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned DATA_W = 32;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    flush;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*ADDR_W-1:0]  req_addr;
    logic [NREQ*DATA_W-1:0]  req_data;
    logic                    rf_wen;
    logic [ADDR_W-1:0]       rf_addrW;
    logic [DATA_W-1:0]       rf_din;
    logic                    iss_valid;
    logic [ADDR_W-1:0]       iss_addr;
    logic                    iss_ready;
    logic [ADDR_W-1:0]       chk_addrA;
    logic [ADDR_W-1:0]       chk_addrB;
    logic                    busyA;
    logic                    busyB;

    always #5 clk = ~clk;

    regfile_wb_sched #(.NREQ(NREQ), .ADDR_W(ADDR_W), .NREGS(NREGS), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rf_wen(rf_wen), .rf_addrW(rf_addrW), .rf_din(rf_din),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .chk_addrA(chk_addrA), .chk_addrB(chk_addrB),
        .busyA(busyA), .busyB(busyB)
    );

    typedef struct packed {
        logic        rst_n;
        logic        flush;
        logic [2:0]  rv;
        logic [17:0] ra;
        logic        iv;
        logic [5:0]  ia;
        logic [5:0]  ca;
        logic [5:0]  cb;
        logic [2:0]  er;
        logic        ei;
        logic        ea;
        logic        eb;
    } vec_t;

    typedef struct packed {
        logic        wen;
        logic [5:0]  addr;
        logic [31:0] din;
    } wb_t;

    vec_t        tbl[$];
    wb_t         sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [5:0]  last_addr = '0;
    logic [31:0] last_din  = '0;

    function automatic vec_t mk(input logic r, input logic f, input logic [2:0] rv,
                                input logic [5:0] a2, input logic [5:0] a1, input logic [5:0] a0,
                                input logic iv, input logic [5:0] ia,
                                input logic [5:0] ca, input logic [5:0] cb,
                                input logic [2:0] er, input logic ei, input logic ea, input logic eb);
        vec_t v;
        v.rst_n = r;  v.flush = f;  v.rv = rv;  v.ra = {a2, a1, a0};
        v.iv = iv;    v.ia = ia;    v.ca = ca;  v.cb = cb;
        v.er = er;    v.ei = ei;    v.ea = ea;  v.eb = eb;
        return v;
    endfunction

    function automatic logic [31:0] data_for(input int k, input int slot);
        if (slot == 0) return (k < 8) ? 32'hDEAD_BEEF : (32'hDEAD_BEEF ^ (32'(k) << 12));
        if (slot == 1) return 32'hCAFE_0000 | 32'(k);
        return 32'h1234_0000 | 32'(k);
    endfunction

    function automatic logic tb_addr_ok(input logic [5:0] a);
        return (a != 6'd0) && (32'(a) < 32'(NREGS));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_wb(input string tag);
        wb_t e;
        if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".rf_wen"},   32'(rf_wen),   32'(e.wen));
            check({tag, ".rf_addrW"}, 32'(rf_addrW), 32'(e.addr));
            check({tag, ".rf_din"},   rf_din,        e.din);
        end
    endtask

    task automatic apply(input vec_t v, input int k);
        wb_t         e;
        logic [31:0] d [3];
        string       tag;
        tag = $sformatf("step%0d", k);
        for (int s = 0; s < 3; s++) d[s] = data_for(k, s);
        @(negedge clk);
        rst_n     = v.rst_n;
        flush     = v.flush;
        req_valid = v.rv;
        req_addr  = v.ra;
        req_data  = {d[2], d[1], d[0]};
        iss_valid = v.iv;
        iss_addr  = v.ia;
        chk_addrA = v.ca;
        chk_addrB = v.cb;
        #1;
        check({tag, ".req_ready"}, 32'(req_ready), 32'(v.er));
        check({tag, ".iss_ready"}, 32'(iss_ready), 32'(v.ei));
        check({tag, ".busyA"},     32'(busyA),     32'(v.ea));
        check({tag, ".busyB"},     32'(busyB),     32'(v.eb));
        // Expected write-port contents after this edge
        if (!v.rst_n) begin
            e = '0;
        end else begin
            e = '{wen: 1'b0, addr: last_addr, din: last_din};
            for (int s = 0; s < 3; s++) begin
                if (v.er[s]) begin
                    e.addr = v.ra[s*6 +: 6];
                    e.din  = d[s];
                    e.wen  = tb_addr_ok(e.addr);
                end
            end
        end
        last_addr = e.addr;
        last_din  = e.din;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_wb(tag);
    endtask

    // Holds inputs; waits a bounded number of cycles for the given slot's grant
    task automatic wait_grant(input int slot, input logic [5:0] a, input logic [31:0] d);
        int n;
        bit got;
        wb_t e;
        n = 0;
        got = 1'b0;
        while (!got && n < 6) begin
            #1;
            if (req_ready != 3'b000) begin
                got = 1'b1;
                check($sformatf("hand.grant%0d", slot), 32'(req_ready), 32'(1) << slot);
                e.wen  = tb_addr_ok(a);
                e.addr = a;
                e.din  = d;
                sb_q.push_back(e);
            end
            @(posedge clk);
            #1;
            if (got) check_wb($sformatf("hand.wb%0d", slot));
            @(negedge clk);
            n++;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL hand.grant_timeout: slot %0d got no grant, required one within 6 cycles", slot);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        iss_valid = 1'b0; iss_addr = '0; chk_addrA = '0; chk_addrB = '0;

        //          rst fl  rv      a2  a1  a0  iv  ia  ca  cb  er      ei ea eb
        tbl.push_back(mk(0, 0, 3'b111,  1,  2,  3, 1,  5,  0,  0, 3'b000, 0, 0, 0)); // 0 reset
        tbl.push_back(mk(1, 0, 3'b000,  0,  0,  0, 1,  5,  5,  0, 3'b000, 1, 0, 0)); // 1 claim x5
        tbl.push_back(mk(1, 0, 3'b001,  0,  0,  5, 0,  0,  5,  5, 3'b001, 1, 1, 1)); // 2 write x5
        tbl.push_back(mk(1, 0, 3'b000,  0,  0,  0, 0,  5,  5,  0, 3'b000, 1, 1, 0)); // 3 retiring
        tbl.push_back(mk(1, 0, 3'b000,  0,  0,  0, 0,  0,  5,  0, 3'b000, 1, 0, 0)); // 4 cleared
        tbl.push_back(mk(1, 0, 3'b100,  9,  0,  0, 0,  0,  0,  0, 3'b100, 1, 0, 0)); // 5 ptr->0
        tbl.push_back(mk(1, 0, 3'b111, 12, 11, 10, 0,  0,  0,  0, 3'b001, 1, 0, 0)); // 6 rr
        tbl.push_back(mk(1, 0, 3'b111, 12, 11, 10, 0,  0,  0,  0, 3'b010, 1, 0, 0)); // 7
        tbl.push_back(mk(1, 0, 3'b111, 12, 11, 10, 0,  0,  0,  0, 3'b100, 1, 0, 0)); // 8
        tbl.push_back(mk(1, 0, 3'b111, 12, 11, 10, 0,  0,  0,  0, 3'b001, 1, 0, 0)); // 9
        tbl.push_back(mk(1, 0, 3'b000,  0,  0,  0, 1,  7,  7,  0, 3'b000, 1, 0, 0)); // 10 claim x7
        tbl.push_back(mk(1, 0, 3'b000,  0,  0,  0, 1,  7,  7,  0, 3'b000, 0, 1, 0)); // 11 WAW stall
        tbl.push_back(mk(1, 0, 3'b010,  0,  7,  0, 1,  7,  7,  0, 3'b010, 0, 1, 0)); // 12 write x7
        tbl.push_back(mk(1, 0, 3'b000,  0,  0,  0, 1,  7,  7,  0, 3'b000, 1, 1, 0)); // 13 reclaim
        tbl.push_back(mk(1, 0, 3'b000,  0,  0,  0, 0,  7,  7,  0, 3'b000, 0, 1, 0)); // 14 still busy
        tbl.push_back(mk(1, 0, 3'b100,  0,  0,  0, 0,  0,  7,  0, 3'b100, 1, 1, 0)); // 15 write x0
        tbl.push_back(mk(1, 0, 3'b111, 13, 12, 40, 0,  0, 12, 40, 3'b001, 1, 0, 0)); // 16 write x40
        tbl.push_back(mk(1, 0, 3'b011,  0, 13, 40, 0,  0,  0,  0, 3'b010, 1, 0, 0)); // 17 ptr moved
        tbl.push_back(mk(1, 0, 3'b000,  0,  0,  0, 1,  3,  7, 13, 3'b000, 1, 1, 0)); // 18 claim x3
        tbl.push_back(mk(1, 0, 3'b001,  0,  0, 20, 1,  4,  3,  4, 3'b001, 1, 1, 0)); // 19 claim x4
        tbl.push_back(mk(1, 1, 3'b001,  0,  0, 21, 1,  8,  3,  4, 3'b000, 0, 1, 1)); // 20 flush
        tbl.push_back(mk(1, 0, 3'b000,  0,  0,  0, 0,  7,  3,  4, 3'b000, 1, 0, 0)); // 21 cleared
        tbl.push_back(mk(1, 0, 3'b001,  0,  0, 22, 1,  9,  9,  0, 3'b001, 1, 0, 0)); // 22 write+claim
        tbl.push_back(mk(0, 0, 3'b111,  1,  2,  3, 1, 10,  9,  0, 3'b000, 0, 1, 0)); // 23 reset mid-write
        tbl.push_back(mk(1, 0, 3'b000,  0,  0,  0, 0,  0,  9,  9, 3'b000, 1, 0, 0)); // 24 busy cleared
        tbl.push_back(mk(1, 0, 3'b111,  3,  2,  1, 0,  0,  0,  0, 3'b001, 1, 0, 0)); // 25 ptr reset
        tbl.push_back(mk(1, 0, 3'b000,  0,  0,  0, 0,  0,  0,  0, 3'b000, 1, 0, 0)); // 26 idle

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k], k);
        end

        // Two held requests with pointer at 1: slot 2 must win before slot 0
        @(negedge clk);
        req_addr  = {6'd17, 6'd0, 6'd16};
        req_data  = {32'hAAAA_0017, 32'h0, 32'h5555_0016};
        req_valid = 3'b101;
        iss_valid = 1'b0;
        wait_grant(2, 6'd17, 32'hAAAA_0017);
        req_valid = 3'b001;
        wait_grant(0, 6'd16, 32'h5555_0016);
        req_valid = 3'b000;
        #1;
        check("hand.idle_ready", 32'(req_ready), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Write-back scheduler for the 2-read/1-write integer register file (x0 hardwired zero).
- Shares the single write port among NREQ write-back requesters (ALU, load unit, mul/div…) using round-robin arbitration.
- Registers the winning write onto the register-file write port.
- Keeps a per-register busy scoreboard so issue logic can detect RAW/WAW hazards against in-flight writes.

Parameters:
- NREQ, 3, number of write-back requesters (2..8)
- ADDR_W, 6, register address width, matching the register-file port width
- NREGS, 32, architectural registers; addresses >= NREGS are treated as x0
- DATA_W, 32, write data width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  pipeline flush: clears the scoreboard
- req_valid  in  NREQ  per-requester write request
- req_ready  out  NREQ  one-hot grant; write accepted this cycle
- req_addr  in  NREQ*ADDR_W  destination register per requester, packed, slot i at [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  write data per requester, packed
- rf_wen  out  1  register-file write enable
- rf_addrW  out  ADDR_W  register-file write address
- rf_din  out  DATA_W  register-file write data
- iss_valid  in  1  issue stage claims a destination register
- iss_addr  in  ADDR_W  destination being claimed
- iss_ready  out  1  claim accepted this cycle
- chk_addrA  in  ADDR_W  source A to hazard-check
- chk_addrB  in  ADDR_W  source B to hazard-check
- busyA  out  1  chk_addrA has a pending write
- busyB  out  1  chk_addrB has a pending write

Behaviour:
- Reset (rst_n=0 at an edge):
  - rf_wen=0, rf_addrW=0, rf_din=0, busy vector all 0, rr_ptr=0.
  - While rst_n=0: req_ready=0 and iss_ready=0 (combinationally forced).
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo NREQ; first set bit i wins.
  - req_ready = one-hot(i); at most one grant per cycle; no grant when flush=1.
  - On a grant, rr_ptr <= (i+1) mod NREQ; otherwise rr_ptr holds.
  - Requesters hold valid/addr/data stable until ready; dropping valid before ready is legal (request withdrawn).
- Output stage (registered):
  - On grant: rf_wen <= (addr valid and != 0), rf_addrW <= req_addr[i], rf_din <= req_data[i].
  - No grant: rf_wen <= 0; rf_addrW and rf_din hold.
  - Latency: grant in cycle N gives the write on the port during cycle N+1; the register file updates at the end of N+1.
  - x0 or out-of-range writes consume the grant but produce rf_wen=0.
- Scoreboard:
  - busy[r] set at the edge where iss_valid & iss_ready & r!=0 & r<NREGS.
  - busy[r] cleared at the edge where rf_wen=1 & rf_addrW=r, the same edge the register file writes.
  - A reader in the following cycle sees busy=0 and the new data.
  - If the same register is cleared and set at one edge, set wins.
- iss_ready:
  - 1 when flush=0 and (iss_addr is x0/out-of-range, or busy[iss_addr]=0, or the output stage is clearing iss_addr this cycle).
  - WAW stalls until the older write retires.
- busyA/busyB = busy[chk_addr], combinational; 0 for x0 or out-of-range addresses.
- Flush:
  - Clears the busy vector at the edge.
  - Blocks grants and claims that cycle.
  - A write already in the output stage still completes.
- Reset mid-write: the pending output-stage write is dropped (rf_wen=0 next cycle).

Test Plan:
- Reset, then iss_valid with iss_addr=5 -> iss_ready=1; next cycle busyA=1 for chk_addrA=5. Req0 valid, addr=5, data=0xDEADBEEF -> req_ready=001; next cycle rf_wen=1, rf_addrW=5, rf_din=0xDEADBEEF; following cycle busyA=0.
- All three requesters valid continuously, rr_ptr=0 -> grants 001, 010, 100, 001 on consecutive cycles; rf_addrW follows the requester order.
- Claim x7 then claim x7 again before write-back -> second claim iss_ready=0 until the cycle rf_wen=1, rf_addrW=7, then iss_ready=1; busy[7] stays 1.
- Write request to addr 0 (and to addr 40) -> granted, rf_wen=0, no register changes, rr_ptr advances.
- Claim x3 and x4, assert flush for one cycle with req_valid=001 -> req_ready=000 that cycle; busyA/B for 3 and 4 read 0 next cycle; an in-flight output-stage write still appears on rf_wen.
- Assert rst_n=0 with rf_wen=1 pending -> next cycle rf_wen=0, all busy=0, req_ready=0 and iss_ready=0 while in reset.
